// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate byte cache with 32-bit lines.
// A miss stalls the CPU while an optional dirty writeback and a line fetch run against data_memory.
module data_cache #(
  parameter int unsigned TAG_W   = 3,
  parameter int unsigned INDEX_W = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       read,
  input  logic                       write,
  input  logic [TAG_W+INDEX_W+1:0]   address,
  input  logic [7:0]                 writedata,
  output logic [7:0]                 readdata,
  output logic                       busywait,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [TAG_W+INDEX_W-1:0]   mem_address,
  output logic [31:0]                mem_writedata,
  input  logic [31:0]                mem_readdata,
  input  logic                       mem_busywait
);

  localparam int unsigned Lines = 2 ** INDEX_W;

  localparam logic [1:0] StIdle      = 2'd0;
  localparam logic [1:0] StWriteback = 2'd1;
  localparam logic [1:0] StFetch     = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [Lines-1:0]         valid_q, dirty_q;
  logic [TAG_W-1:0]         tag_q  [Lines];
  logic [31:0]              data_q [Lines];
  logic [TAG_W+INDEX_W-1:0] mem_addr_q;
  logic [31:0]              mem_wdata_q;
  logic [7:0]               readdata_q;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   req_tag;
  logic [1:0]         offset;
  logic [4:0]         bit_base;
  logic [31:0]        line;
  logic               access, hit;

  assign idx      = address[INDEX_W+1:2];
  assign req_tag  = address[TAG_W+INDEX_W+1:INDEX_W+2];
  assign offset   = address[1:0];
  assign bit_base = {offset, 3'b000};
  assign line     = data_q[idx];
  assign access   = read ^ write;
  assign hit      = valid_q[idx] && (tag_q[idx] == req_tag);

  // Outputs are forced quiet while reset is held, whatever the CPU drives.
  assign busywait      = reset && access && !((state_q == StIdle) && hit);
  assign mem_write     = (state_q == StWriteback);
  assign mem_read      = (state_q == StFetch);
  assign mem_address   = mem_addr_q;
  assign mem_writedata = mem_wdata_q;

  always_comb begin
    readdata = readdata_q;
    if (!reset) begin
      readdata = '0;
    end else if (read) begin
      readdata = line[bit_base +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (access && !hit) begin
          state_d = (valid_q[idx] && dirty_q[idx]) ? StWriteback : StFetch;
        end
      end
      StWriteback: if (!mem_busywait) state_d = StFetch;
      StFetch:     if (!mem_busywait) state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      readdata_q  <= '0;
      for (int unsigned i = 0; i < Lines; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      readdata_q <= readdata;

      if ((state_q == StIdle) && write && !read && hit) begin
        data_q[idx][bit_base +: 8] <= writedata;
        dirty_q[idx]               <= 1'b1;
      end

      // Victim address and data are latched once; the line is untouched until the fetch lands.
      if ((state_q == StIdle) && (state_d == StWriteback)) begin
        mem_addr_q  <= {tag_q[idx], idx};
        mem_wdata_q <= data_q[idx];
      end

      if ((state_d == StFetch) && (state_q != StFetch)) begin
        mem_addr_q <= {req_tag, idx};
      end

      if ((state_q == StFetch) && !mem_busywait) begin
        data_q[idx]  <= mem_readdata;
        tag_q[idx]   <= req_tag;
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: a vector table of CPU accesses with expected memory traffic,
// plus hand-written reset and reset-during-fetch sequences.
module tb_data_cache;

  logic        clock = 1'b0;
  logic        reset;
  logic        read, write;
  logic [7:0]  address, writedata, readdata;
  logic        busywait, mem_read, mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata, mem_readdata;
  logic        mem_busywait;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  data_cache #(.TAG_W(3), .INDEX_W(3)) dut (
    .clock         (clock),
    .reset         (reset),
    .read          (read),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata),
    .busywait      (busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  // Block memory: busy for the first three cycles of each new request.
  logic [31:0] mem [64];
  logic [1:0]  prev_req;
  int unsigned mcnt;
  logic        mem_load = 1'b0;

  assign mem_readdata = mem[mem_address];
  assign mem_busywait = (mem_read || mem_write) &&
                        (({mem_read, mem_write} != prev_req) || (mcnt < 2));

  always @(posedge clock or posedge mem_load) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[6'h00] <= 32'h44332211;
      mem[6'h01] <= 32'h88776655;
      mem[6'h09] <= 32'hDDCCBBAA;
      mem[6'h11] <= 32'h0F1E2D3C;
      mem[6'h38] <= 32'hF0E0D0C0;
      prev_req   <= 2'b00;
      mcnt       <= 0;
    end else begin
      if ({mem_read, mem_write} != prev_req) mcnt <= 0;
      else if (mcnt < 100) mcnt <= mcnt + 1;
      prev_req <= {mem_read, mem_write};
      if (mem_write && !mem_busywait) mem[mem_address] <= mem_writedata;
    end
  end

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic        stall;
    logic        wb;
    logic [5:0]  wb_addr;
    logic [31:0] wb_data;
    logic        fetch;
    logic [5:0]  fetch_addr;
    logic [7:0]  rdata;
  } vec_t;

  function automatic vec_t mk(input string name, input logic rd, input logic wr,
                              input logic [7:0] addr, input logic [7:0] wdata,
                              input logic stall, input logic wb, input logic [5:0] wb_addr,
                              input logic [31:0] wb_data, input logic fetch,
                              input logic [5:0] fetch_addr, input logic [7:0] rdata);
    vec_t v;
    v.name = name; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.stall = stall; v.wb = wb; v.wb_addr = wb_addr; v.wb_data = wb_data;
    v.fetch = fetch; v.fetch_addr = fetch_addr; v.rdata = rdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic        saw_wb, saw_fetch, first_busy, both;
    logic [5:0]  wa, fa;
    logic [31:0] wd;
    int          n;
    saw_wb = 0; saw_fetch = 0; both = 0; wa = '0; fa = '0; wd = '0; n = 0;
    @(posedge clock); #1;
    read = v.rd; write = v.wr; address = v.addr; writedata = v.wdata;
    @(negedge clock);
    first_busy = busywait;
    while (busywait && n < 60) begin
      if (mem_write) begin saw_wb = 1; wa = mem_address; wd = mem_writedata; end
      if (mem_read) begin saw_fetch = 1; fa = mem_address; end
      if (mem_read && mem_write) both = 1;
      @(negedge clock);
      n++;
    end
    if (mem_write) saw_wb = 1;
    if (mem_read) saw_fetch = 1;
    check({v.name, " stall"}, first_busy, v.stall);
    check({v.name, " busywait released"}, busywait, 1'b0);
    check({v.name, " writeback seen"}, saw_wb, v.wb);
    if (v.wb) begin
      check({v.name, " writeback addr"}, wa, v.wb_addr);
      check({v.name, " writeback data"}, wd, v.wb_data);
    end
    check({v.name, " fetch seen"}, saw_fetch, v.fetch);
    if (v.fetch) check({v.name, " fetch addr"}, fa, v.fetch_addr);
    check({v.name, " read/write exclusive"}, both, 1'b0);
    if (v.rd && !v.wr) check({v.name, " readdata"}, readdata, v.rdata);
    @(posedge clock); #1;
    read = 0; write = 0;
  endtask

  vec_t vecs[13];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0]  = mk("T1 read 00 miss",   1, 0, 8'h00, 8'h00, 1, 0, 6'h00, 32'h0,        1, 6'h00, 8'h11);
    vecs[1]  = mk("T2 read 02 hit",    1, 0, 8'h02, 8'h00, 0, 0, 6'h00, 32'h0,        0, 6'h00, 8'h33);
    vecs[2]  = mk("T3 write 05 miss",  0, 1, 8'h05, 8'hAB, 1, 0, 6'h00, 32'h0,        1, 6'h01, 8'h00);
    vecs[3]  = mk("T3 read 05 hit",    1, 0, 8'h05, 8'h00, 0, 0, 6'h00, 32'h0,        0, 6'h00, 8'hAB);
    vecs[4]  = mk("T4 read 25 wb",     1, 0, 8'h25, 8'h00, 1, 1, 6'h01, 32'h8877AB55, 1, 6'h09, 8'hBB);
    vecs[5]  = mk("read 05 clean miss",1, 0, 8'h05, 8'h00, 1, 0, 6'h00, 32'h0,        1, 6'h01, 8'hAB);
    vecs[6]  = mk("write 03 hit",      0, 1, 8'h03, 8'h5C, 0, 0, 6'h00, 32'h0,        0, 6'h00, 8'h00);
    vecs[7]  = mk("read 03 hit",       1, 0, 8'h03, 8'h00, 0, 0, 6'h00, 32'h0,        0, 6'h00, 8'h5C);
    vecs[8]  = mk("read E3 wb",        1, 0, 8'hE3, 8'h00, 1, 1, 6'h00, 32'h5C332211, 1, 6'h38, 8'hF0);
    vecs[9]  = mk("T6 rd+wr 00",       1, 1, 8'h00, 8'h77, 0, 0, 6'h00, 32'h0,        0, 6'h00, 8'h00);
    vecs[10] = mk("T6 rd+wr E3",       1, 1, 8'hE3, 8'h12, 0, 0, 6'h00, 32'h0,        0, 6'h00, 8'h00);
    vecs[11] = mk("T6 read E3 intact", 1, 0, 8'hE3, 8'h00, 0, 0, 6'h00, 32'h0,        0, 6'h00, 8'hF0);
    vecs[12] = mk("read 03 refetch",   1, 0, 8'h03, 8'h00, 1, 0, 6'h00, 32'h0,        1, 6'h00, 8'h5C);

    reset = 0; read = 0; write = 0; address = 8'h00; writedata = 8'h00;
    #1 mem_load = 1;
    #1 mem_load = 0;
    #10;
    check("reset busywait", busywait, 1'b0);
    check("reset mem_read", mem_read, 1'b0);
    check("reset mem_write", mem_write, 1'b0);
    check("reset mem_address", mem_address, 6'h00);
    check("reset mem_writedata", mem_writedata, 32'h0);
    check("reset readdata", readdata, 8'h00);
    read = 1;
    #1;
    check("reset busywait with read", busywait, 1'b0);
    read = 0;
    @(negedge clock);
    reset = 1;

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Reset landing mid-fetch must drop the transfer and leave the line invalid.
    @(posedge clock); #1;
    read = 1; address = 8'h45;
    n = 0;
    @(negedge clock);
    while (!mem_read && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("T5 reached fetch", mem_read, 1'b1);
    #2 reset = 0;
    #1;
    check("T5 mem_read dropped", mem_read, 1'b0);
    check("T5 mem_write low", mem_write, 1'b0);
    check("T5 busywait dropped", busywait, 1'b0);
    check("T5 mem_address cleared", mem_address, 6'h00);
    read = 0;
    @(negedge clock);
    reset = 1;
    run_vec(mk("T5 read 45 misses", 1, 0, 8'h45, 8'h00, 1, 0, 6'h00, 32'h0, 1, 6'h11, 8'h2D));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
